vga_pixel_arbiter: RTL and testbench

- Shares the single VGA adapter pixel-write port (x, y, colour, writeEn) between several sprite drawers: ship drawer, bullet drawer and asteroid drawer.
- Each drawer raises a request, waits for a one-hot grant, then streams pixels.
- The block grants round-robin, limits burst length so no drawer starves the others, and registers the winning pixel onto the adapter port.
- Sits between the drawer modules and the vga_adapter instance in the top level.

---
 rtl/vga_pixel_arbiter.sv | 120 ++++++++++++
 tb/tb_vga_pixel_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_arbiter.sv
// vga_pixel_arbiter: round-robin share of the VGA adapter pixel port among sprite drawers with burst-limited grants.
// Optional VGA_CLIP_EN: accepted pixels outside the 160x120 frame are consumed but not written.
module vga_pixel_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     pix_valid,
    input  logic [NUM_REQ*X_W-1:0] x_in,
    input  logic [NUM_REQ*Y_W-1:0] y_in,
    input  logic [NUM_REQ*C_W-1:0] colour_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_writeEn,
    output logic                   busy
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    typedef enum logic {S_IDLE, S_OWN} state_t;
    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        r_last;
    logic [7:0]           r_burst_cnt;
    logic [X_W-1:0]       r_x;
    logic [Y_W-1:0]       r_y;
    logic [C_W-1:0]       r_c;
    logic                 r_we;
    logic [X_W-1:0]       w_x [NUM_REQ];
    logic [Y_W-1:0]       w_y [NUM_REQ];
    logic [C_W-1:0]       w_c [NUM_REQ];
    logic [IW-1:0]        w_idx;
    logic [IW-1:0]        w_win;
    logic                 w_acc;
    logic                 w_wr;
    logic                 w_others;
    logic [7:0]           w_cnt_nx;
    genvar g;
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_x[g] = x_in[g*X_W +: X_W];
        assign w_y[g] = y_in[g*Y_W +: Y_W];
        assign w_c[g] = colour_in[g*C_W +: C_W];
    end
    // Descending scan so the last hit is the nearest requester after r_last.
    always_comb begin
        w_idx = '0;
        w_win = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = IW'((32'(r_last) + 32'(i)) % NUM_REQ);
            if (req[w_idx]) w_win = w_idx;
        end
    end
    assign w_acc    = (r_state == S_OWN) && pix_valid[r_owner];
    assign w_cnt_nx = r_burst_cnt + 8'(w_acc);
    assign w_others = |(req & ~r_grant);
`ifdef VGA_CLIP_EN
    assign w_wr = w_acc && (32'(w_x[r_owner]) < 32'd160) && (32'(w_y[r_owner]) < 32'd120);
`else
    assign w_wr = w_acc;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_last      <= IW'(NUM_REQ - 1);
            r_burst_cnt <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_c         <= '0;
            r_we        <= 1'b0;
        end else begin
            r_we <= w_wr;
            if (w_wr) begin
                r_x <= w_x[r_owner];
                r_y <= w_y[r_owner];
                r_c <= w_c[r_owner];
            end
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state     <= S_OWN;
                        r_grant     <= NUM_REQ'(1) << w_win;
                        r_owner     <= w_win;
                        r_last      <= w_win;
                        r_burst_cnt <= '0;
                    end
                end
                S_OWN: begin
                    if (!req[r_owner]) begin
                        r_state     <= S_IDLE;
                        r_grant     <= '0;
                        r_burst_cnt <= '0;
                    end else if (w_cnt_nx == 8'(MAX_BURST)) begin
                        r_burst_cnt <= '0;
                        if (w_others) begin
                            r_state <= S_IDLE;
                            r_grant <= '0;
                        end
                    end else begin
                        r_burst_cnt <= w_cnt_nx;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign grant       = r_grant;
    assign busy        = |r_grant;
    assign vga_x       = r_x;
    assign vga_y       = r_y;
    assign vga_colour  = r_c;
    assign vga_writeEn = r_we;
endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// tb_vga_pixel_arbiter: scenario tasks plus randomized traffic checked against a behavioural arbiter model.
module tb_vga_pixel_arbiter;
    localparam int NR = 3;
    localparam int MB = 16;
    logic        clk = 0;
    logic        reset = 0;
    logic [2:0]  req = '0;
    logic [2:0]  pix_valid = '0;
    logic [23:0] x_in = '0;
    logic [20:0] y_in = '0;
    logic [8:0]  colour_in = '0;
    logic [2:0]  grant;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_writeEn;
    logic        busy;
    int n_run = 0;
    int n_fail = 0;
    int m_owner = -1;
    int m_last = NR - 1;
    int m_cnt = 0;
    bit m_we = 0;
    logic [7:0] m_x = '0;
    logic [6:0] m_y = '0;
    logic [2:0] m_c = '0;

    vga_pixel_arbiter #(.NUM_REQ(NR), .X_W(8), .Y_W(7), .C_W(3), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_writeEn(vga_writeEn), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input string tag);
        bit acc, clip, found;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc, eg;
        int w;
        px = '0; py = '0; pc = '0;
        acc = !reset && m_owner >= 0 && pix_valid[m_owner];
        if (m_owner >= 0) begin
            px = x_in[m_owner*8 +: 8];
            py = y_in[m_owner*7 +: 7];
            pc = colour_in[m_owner*3 +: 3];
        end
`ifdef VGA_CLIP_EN
        clip = px >= 8'd160 || py >= 7'd120;
`else
        clip = 0;
`endif
        if (reset) begin
            m_owner = -1; m_last = NR - 1; m_cnt = 0; m_we = 0;
            m_x = '0; m_y = '0; m_c = '0;
        end else begin
            m_we = acc && !clip;
            if (m_we) begin m_x = px; m_y = py; m_c = pc; end
            if (m_owner < 0) begin
                found = 0; w = 0;
                for (int k = 1; k <= NR; k++)
                    if (!found && req[(m_last + k) % NR]) begin found = 1; w = (m_last + k) % NR; end
                if (found) begin m_owner = w; m_last = w; m_cnt = 0; end
            end else if (!req[m_owner]) begin
                m_owner = -1;
                m_cnt = 0;
            end else begin
                m_cnt += int'(acc);
                if (m_cnt == MB) begin
                    m_cnt = 0;
                    if ((req & ~(3'b001 << m_owner)) != 0) m_owner = -1;
                end
            end
        end
        eg = m_owner < 0 ? 3'b000 : 3'b001 << m_owner;
        @(posedge clk);
        #1;
        n_run += 6;
        if (grant !== eg) begin n_fail++; $display("FAIL %s grant got %b exp %b", tag, grant, eg); end
        if (busy !== (eg != 0)) begin n_fail++; $display("FAIL %s busy got %b exp %b", tag, busy, eg != 0); end
        if (vga_writeEn !== m_we) begin n_fail++; $display("FAIL %s writeEn got %b exp %b", tag, vga_writeEn, m_we); end
        if (vga_x !== m_x) begin n_fail++; $display("FAIL %s vga_x got %0d exp %0d", tag, vga_x, m_x); end
        if (vga_y !== m_y) begin n_fail++; $display("FAIL %s vga_y got %0d exp %0d", tag, vga_y, m_y); end
        if (vga_colour !== m_c) begin n_fail++; $display("FAIL %s colour got %0d exp %0d", tag, vga_colour, m_c); end
    endtask

    task automatic do_reset();
        reset = 1; req = '0; pix_valid = '0;
        tick("reset");
        reset = 0;
    endtask

    task automatic rand_px();
        x_in = 24'($urandom);
        y_in = 21'($urandom);
        colour_in = 9'($urandom);
    endtask

    task automatic test_reset();
        reset = 1; req = 3'b111; pix_valid = 3'b111; rand_px();
        tick("reset_state");
        reset = 0; req = '0; pix_valid = '0;
    endtask

    task automatic test_single();
        int pulses = 0;
        do_reset();
        req = 3'b001;
        tick("single_grant");
        pix_valid = 3'b001;
        for (int i = 0; i < 4; i++) begin
            rand_px();
            tick("single_px");
            pulses += int'(vga_writeEn);
        end
        req = '0; pix_valid = '0;
        tick("single_drop");
        pulses += int'(vga_writeEn);
        n_run++;
        if (pulses != 4) begin n_fail++; $display("FAIL single_pulses got %0d exp 4", pulses); end
    endtask

    task automatic test_round_robin();
        logic [2:0] seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        logic [2:0] prev = '0;
        int nr = 0, pulses = 0, dead = 0;
        do_reset();
        req = 3'b111; pix_valid = 3'b111;
        for (int i = 0; i < 55; i++) begin
            rand_px();
            tick("rr");
            if (vga_writeEn) pulses++;
            if (grant != 0 && prev == 0) begin
                if (nr > 0) begin
                    n_run += 2;
                    if (pulses != MB) begin n_fail++; $display("FAIL rr_pulses got %0d exp %0d", pulses, MB); end
                    if (dead != 1) begin n_fail++; $display("FAIL rr_dead got %0d exp 1", dead); end
                end
                if (nr < 4) begin
                    n_run++;
                    if (grant !== seq[nr]) begin n_fail++; $display("FAIL rr_seq%0d got %b exp %b", nr, grant, seq[nr]); end
                end
                nr++; pulses = 0; dead = 0;
            end else if (grant == 0) dead++;
            prev = grant;
        end
        n_run++;
        if (nr != 4) begin n_fail++; $display("FAIL rr_grants got %0d exp 4", nr); end
        req = '0; pix_valid = '0;
    endtask

    task automatic test_long_burst();
        int pulses = 0;
        do_reset();
        req = 3'b010;
        tick("long_grant");
        pix_valid = 3'b010;
        for (int i = 0; i < 40; i++) begin
            rand_px();
            tick("long_px");
            pulses += int'(vga_writeEn);
        end
        n_run++;
        if (pulses != 40) begin n_fail++; $display("FAIL long_pulses got %0d exp 40", pulses); end
        req = '0; pix_valid = '0;
    endtask

    task automatic test_ignore();
        do_reset();
        req = 3'b010;
        tick("ign_grant");
        pix_valid = 3'b110;
        for (int i = 0; i < 6; i++) begin
            rand_px();
            x_in[15:8] = 8'd9 + 8'($urandom_range(0, 100));
            x_in[23:16] = 8'd5;
            tick("ign_px");
            n_run++;
            if (vga_writeEn && vga_x == 8'd5) begin n_fail++; $display("FAIL ignore_x got %0d exp not 5", vga_x); end
        end
        req = '0; pix_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 3'b001;
        tick("rmid_grant");
        pix_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin rand_px(); tick("rmid_px"); end
        reset = 1; rand_px();
        tick("rmid_reset");
        n_run += 2;
        if (grant !== 3'b000) begin n_fail++; $display("FAIL rmid_grant got %b exp 000", grant); end
        if (vga_writeEn !== 1'b0) begin n_fail++; $display("FAIL rmid_we got %b exp 0", vga_writeEn); end
        reset = 0; req = 3'b101; pix_valid = '0;
        tick("rmid_regrant");
        n_run++;
        if (grant !== 3'b001) begin n_fail++; $display("FAIL rmid_first got %b exp 001", grant); end
        req = '0;
    endtask

    task automatic test_clip();
        do_reset();
        req = 3'b011;
        tick("clip_grant");
        pix_valid = 3'b001;
        x_in[7:0] = 8'd170; y_in[6:0] = 7'd10; colour_in[2:0] = 3'd6;
        tick("clip_px");
        n_run++;
`ifdef VGA_CLIP_EN
        if (vga_writeEn !== 1'b0) begin n_fail++; $display("FAIL clip_we got %b exp 0", vga_writeEn); end
`else
        if (vga_writeEn !== 1'b1 || vga_x !== 8'd170) begin
            n_fail++; $display("FAIL clip_we got %b/%0d exp 1/170", vga_writeEn, vga_x);
        end
`endif
        for (int i = 0; i < MB - 1; i++) begin
            x_in[7:0] = 8'($urandom_range(0, 159)); y_in[6:0] = 7'($urandom_range(0, 119));
            tick("clip_burst");
        end
        n_run++;
        if (grant !== 3'b000) begin n_fail++; $display("FAIL clip_release got %b exp 000", grant); end
        req = '0; pix_valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 2)] ^= 1'b1;
            pix_valid = 3'($urandom);
            rand_px();
            reset = ($urandom_range(0, 299) == 0);
            tick("random");
        end
        reset = 0; req = '0; pix_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_long_burst();
        test_ignore();
        test_reset_mid();
        test_clip();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
